// File: rtl/crc_checker_if.sv
// Stream, result and error-count signals of the CRC checker, bundled so the
// checker and its environment share one declaration.
//   master : the environment (drives the input stream and downstream ready)
//   slave  : the checker itself
interface crc_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  logic                  result_valid;
  logic                  result_ok;
  logic                  result_runt;
  logic [CRC_WIDTH-1:0]  result_crc;
  logic [15:0]           err_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  result_valid, result_ok, result_runt, result_crc, err_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output result_valid, result_ok, result_runt, result_crc, err_count
  );
endinterface

// File: rtl/crc_checker.sv
// Receive-side CRC checker. Each frame is payload words followed by
// NW = CRC_WIDTH/DATA_WIDTH CRC words (MSB word first). The trailing CRC words
// are held back in an NW-deep delay line so they never reach the output; every
// word that falls out of the delay line is payload, is forwarded downstream and
// is folded into the running CRC. On the last word the delay line holds the
// received CRC, which is compared against the computed one. CRC_WIDTH must be
// a multiple of DATA_WIDTH.
module crc_checker #(
  parameter int                   DATA_WIDTH  = 8,
  parameter int                   CRC_WIDTH   = 16,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = 'h1021,
  parameter logic [CRC_WIDTH-1:0] SEED_VAL    = '0,
  parameter logic [CRC_WIDTH-1:0] OUTPUT_EXOR = '0
) (
  input logic          clk,
  input logic          rst,
  crc_checker_if.slave bus
);

  localparam int NW = CRC_WIDTH / DATA_WIDTH;
  localparam int FW = $clog2(NW + 1);

  // One stream word folded into the CRC, MSB first, bit-serial definition.
  function automatic logic [CRC_WIDTH-1:0] crc_word(
    input logic [CRC_WIDTH-1:0]  c,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;
    r = c;
    for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
      fb = r[CRC_WIDTH-1] ^ d[b];
      r  = r << 1;
      if (fb) r = r ^ POLYNOMIAL;
    end
    return r;
  endfunction

  // Delay line kept as a flat vector: oldest word in the top slice, newest in
  // the bottom slice, so after a shift the vector reads directly as the
  // received CRC {oldest..newest}.
  logic [CRC_WIDTH-1:0]  dly;
  logic [FW-1:0]         fill;
  logic [CRC_WIDTH-1:0]  crc;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  result_valid;
  logic                  result_ok;
  logic                  result_runt;
  logic [CRC_WIDTH-1:0]  result_crc;
  logic [15:0]           err_count;

  logic                  in_ready;
  logic                  accept;
  logic                  full;
  logic [DATA_WIDTH-1:0] oldest;
  logic [CRC_WIDTH-1:0]  dly_sh;
  logic [CRC_WIDTH-1:0]  crc_emit;
  logic [CRC_WIDTH-1:0]  final_crc;
  logic                  frame_ok;
  logic                  frame_bad;

  // Output register can take a new word whenever it is empty or draining.
  assign in_ready  = !out_valid | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  assign full      = (fill == FW'(NW));
  assign oldest    = dly[CRC_WIDTH-1 -: DATA_WIDTH];
  assign dly_sh    = (dly << DATA_WIDTH) | CRC_WIDTH'(bus.in_data);
  assign crc_emit  = crc_word(crc, oldest);
  assign final_crc = crc_emit ^ OUTPUT_EXOR;
  assign frame_ok  = full && (dly_sh == final_crc);
  assign frame_bad = !frame_ok;

  // Delay line, payload output register, running CRC and per-frame result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly          <= '0;
      fill         <= '0;
      crc          <= SEED_VAL;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      result_runt  <= 1'b0;
      result_crc   <= '0;
      err_count    <= '0;
    end else begin
      result_valid <= 1'b0;
      if (bus.out_ready) out_valid <= 1'b0;

      if (accept) begin
        dly <= dly_sh;
        if (full) begin
          // Delay line primed: the word pushed out is payload.
          out_valid <= 1'b1;
          out_data  <= oldest;
          out_last  <= bus.in_last;
          crc       <= crc_emit;
        end else begin
          fill <= fill + FW'(1);
        end

        if (bus.in_last) begin
          // Frame closes; next frame may start on the very next cycle.
          crc          <= SEED_VAL;
          fill         <= '0;
          result_valid <= 1'b1;
          result_runt  <= !full;
          result_ok    <= frame_ok;
          result_crc   <= full ? final_crc : (SEED_VAL ^ OUTPUT_EXOR);
          if (frame_bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_last     = out_last;
  assign bus.result_valid = result_valid;
  assign bus.result_ok    = result_ok;
  assign bus.result_runt  = result_runt;
  assign bus.result_crc   = result_crc;
  assign bus.err_count    = err_count;

endmodule
